ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Serial configuration loader that drives the `ccff_head` input of a connection-block configuration chain and packs the bits leaving `ccff_tail` into readback words. It sits directly upstream of the chain of mux memories.

- **Load path:** accepts bitstream words over a valid/ready handshake and shifts them one bit per cycle.
- **Shift qualification:** each shift is marked by `ccff_en`, which feeds an external `prog_clk` gate.
- **Readback path:** the previous chain contents return on the readback handshake.

## Interface
Parameters:
- `CHAIN_LEN`, default 58: number of configuration bits in the downstream chain (9×6 + 2×2).
- `WORD_W`, default 8: bitstream and readback word width.

Ports:
- `prog_clk`  in  1  configuration clock; all state on rising edge.
- `pReset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `word_valid`  in  1  bitstream word available.
- `word_data`  in  `WORD_W`  bitstream word; MSB shifted first.
- `word_ready`  out  1  loader accepts `word_data` this cycle.
- `ccff_head`  out  1  serial bit into chain.
- `ccff_en`  out  1  chain shifts at the next `prog_clk` edge.
- `ccff_tail`  in  1  serial bit out of chain.
- `rb_valid`  out  1  readback word available.
- `rb_data`  out  `WORD_W`  readback word; first bit out is in the MSB.
- `rb_ready`  in  1  readback consumer accepts `rb_data`.
- `busy`  out  1  high from LOAD entry until DONE exit.
- `done`  out  1  one-cycle pulse when the load completes.

## Operation
- **States:** IDLE, LOAD, FLUSH, DONE.
- **IDLE:**
  - `start` moves to LOAD.
  - `bit_cnt` clears to `CHAIN_LEN`.
- **LOAD:**
  - A shift occurs in any cycle where the word holding register has at least 1 bit, `bit_cnt` > 0, and the readback stall is false.
  - On a shift: `ccff_en`=1, `ccff_head`=holding MSB, the holding register shifts left, and `bit_cnt` decrements.
  - `ccff_tail` is sampled into the readback packer on every shift.
- **Readback stall:** `rb_valid`=1 and `rb_ready`=0. When stalled, `ccff_en`=0 and no state changes except handshakes.
- **Word fetch:**
  - `word_ready`=1 in LOAD when the holding register is empty, or its last bit shifts this cycle, and bits remain beyond the current word.
  - This allows gap-free back-to-back words.
- **Partial final word:** number of words = ceil(`CHAIN_LEN`/`WORD_W`). Only the top `CHAIN_LEN` mod `WORD_W` bits of the final word are shifted (all of them if the remainder is 0). The remaining bits are discarded.
- **End of load:** when `bit_cnt` reaches 0, go to FLUSH.
  - FLUSH emits any partial readback word, left-justified and zero-padded, then goes to DONE.
  - If there is no partial word, FLUSH lasts 1 cycle.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Readback packer:**
  - `rb_valid` rises the cycle after `WORD_W` bits are collected, or in FLUSH for a partial word.
  - It holds until `rb_ready`.
  - `rb_data` is stable while `rb_valid`=1.
- **Ignored `start`:** `start` outside IDLE has no effect.
- **Bitstream starvation:** `word_valid`=0 with an empty holding register gives `ccff_en`=0 and no state change.
- **Counter widths:**
  - `bit_cnt` is `$clog2(CHAIN_LEN+1)` bits.
  - The per-word counter is `$clog2(WORD_W+1)` bits.
  - No wrap is permitted; the counters saturate at 0.

## Timing
- **Reset values:**
  - `ccff_head`=0, `ccff_en`=0, `word_ready`=0, `rb_valid`=0, `rb_data`=0, `busy`=0, `done`=0.
  - State is IDLE.
- **Reset mid-load:** `pReset` asserted mid-load forces all of the above immediately. Chain contents are then undefined, and no `done` is issued.
- **Start latency:** `start` at cycle 0 gives `busy`=1 and `word_ready`=1 at cycle 1.
- **First shift:** a word accepted at cycle N gives its first shift at cycle N+1.
- **Throughput:** 1 bit/cycle with no stalls. A full load takes `CHAIN_LEN` shift cycles + 1 fetch cycle + FLUSH + DONE.
- **Readback latency:** `rb_valid` rises 1 cycle after the shift that completes the word.
- **Simultaneous events:** `rb_ready` and a new full word completing in the same cycle give a new `rb_valid` with no gap.

## Structure
- **Package `ccff_loader_pkg`:**
  - state enum `ccff_ld_state_t` {IDLE, LOAD, FLUSH, DONE}.
  - function `ccff_num_words(len, w)`.
  - function `ccff_last_bits(len, w)`.
- **Sub-module `ccff_rb_packer`:** serial-to-word packer with valid/ready, a flush input and a stall output.

## Test plan
- **Nominal load:** defaults; 8 words 0xA5,0x3C,…,last 0xC0 with ready always high.
  - Exactly 58 `ccff_en` pulses.
  - `ccff_head` sequence equals the MSB-first bits; the final word contributes bits 7:6 only.
  - `done` pulse at cycle 60 after the first accept.
- **Readback after reload:** load pattern P1, then P2.
  - The second load's `rb_data` words equal P1 re-packed: 7 full words plus a final word with 2 bits left-justified (e.g. 0x40/0x80/0xC0/0x00).
- **Starvation:** `word_valid` dropped for 5 cycles mid-word-3.
  - `ccff_en` is low exactly 5 cycles.
  - Bit order is unchanged; total pulses = 58.
- **Readback backpressure:** `rb_ready` held low 10 cycles after the first `rb_valid`.
  - `ccff_en` is 0 during the stall.
  - `rb_data` is stable, and no bits are lost.
- **Reset mid-load:** `pReset` low at bit 30.
  - All outputs go to reset values in the same cycle.
  - No `done`.
  - A subsequent `start` performs a full 58-bit load.
- **Ignored start:** `start` asserted while `busy`=1 has no effect; exactly one `done`.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } ccff_ld_state_t;

  // Number of bitstream words needed to cover a chain of len bits.
  function automatic int ccff_num_words(input int len, input int w);
    return (len + w - 1) / w;
  endfunction

  // Bits of the final word that actually enter the chain.
  function automatic int ccff_last_bits(input int len, input int w);
    return ((len % w) == 0) ? w : (len % w);
  endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Serial-to-word packer for bits leaving the chain tail; MSB holds the first bit.
// Latency: word valid 1 cycle after its last bit; partial word valid 1 cycle after flush.
// Backpressure: word held until i_rb_ready; o_stall tells the loader to freeze shifting.
// Ports: prog_clk/pReset clock and async active-low reset; i_shift/i_tail serial bit in;
//        i_flush emits a partial word; o_rb_valid/o_rb_data/i_rb_ready readback handshake.
module ccff_rb_packer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              i_shift,
  input  logic              i_tail,
  input  logic              i_flush,
  input  logic              i_rb_ready,
  output logic              o_rb_valid,
  output logic [WORD_W-1:0] o_rb_data,
  output logic              o_stall
);

  localparam int HW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] r_sr;
  logic [HW-1:0]     r_cnt;
  logic              r_rb_valid;
  logic [WORD_W-1:0] r_rb_data;

  logic [WORD_W-1:0] w_sr_nxt;
  logic              w_stall;
  logic              w_word_done;
  logic              w_flush_push;

  assign w_stall      = r_rb_valid && !i_rb_ready;
  // Collected bits sit right-aligned; stale upper bits fall off on emit.
  assign w_sr_nxt     = (r_sr << 1) | WORD_W'(i_tail);
  assign w_word_done  = i_shift && (r_cnt == HW'(WORD_W - 1));
  assign w_flush_push = i_flush && !w_stall && (r_cnt != '0);

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_sr       <= '0;
      r_cnt      <= '0;
      r_rb_valid <= 1'b0;
      r_rb_data  <= '0;
    end else begin
      if (r_rb_valid && i_rb_ready) r_rb_valid <= 1'b0;
      // A completing word may replace one being consumed this cycle: no bubble.
      if (w_word_done) begin
        r_rb_data  <= w_sr_nxt;
        r_rb_valid <= 1'b1;
        r_cnt      <= '0;
      end else if (i_shift) begin
        r_sr  <= w_sr_nxt;
        r_cnt <= r_cnt + HW'(1);
      end
      if (w_flush_push) begin
        // Left-justify the partial word, zero-padded below.
        r_rb_data  <= r_sr << (HW'(WORD_W) - r_cnt);
        r_rb_valid <= 1'b1;
        r_cnt      <= '0;
      end
    end
  end

  assign o_rb_valid = r_rb_valid;
  assign o_rb_data  = r_rb_data;
  assign o_stall    = w_stall;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serial loader feeding ccff_head of a config chain and packing ccff_tail into readback words.
// Latency: start->word_ready 1 cycle; word accept->first shift 1 cycle; 1 bit/cycle gap-free.
// Backpressure: shifting (ccff_en) freezes on bitstream starvation or a stalled readback word.
// Ports: prog_clk/pReset clock and async active-low reset; start load request;
//        word_valid/word_data/word_ready bitstream in; ccff_head/ccff_en/ccff_tail chain side;
//        rb_valid/rb_data/rb_ready readback out; busy/done status.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 58,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data,
  input  logic              rb_ready,
  output logic              busy,
  output logic              done
);

  localparam int CW        = $clog2(CHAIN_LEN + 1);
  localparam int HW        = $clog2(WORD_W + 1);
  localparam int NUM_WORDS = ccff_num_words(CHAIN_LEN, WORD_W);
  localparam int LAST_BITS = ccff_last_bits(CHAIN_LEN, WORD_W);
  localparam int NW        = $clog2(NUM_WORDS + 1);

  ccff_ld_state_t r_state, w_state_nxt;

  logic [CW-1:0]     r_bit_cnt;
  logic [WORD_W-1:0] r_hold;
  logic [HW-1:0]     r_hold_cnt;
  logic [NW-1:0]     r_words_left;

  logic w_stall;
  logic w_shift;
  logic w_fetch;
  logic w_accept;
  logic w_flush;

  assign w_shift  = (r_state == LOAD) && (r_hold_cnt != '0) && (r_bit_cnt != '0) && !w_stall;
  // Fetch when the holding register is empty or drains this cycle, so words chain without gaps.
  assign w_fetch  = (r_state == LOAD) && (r_words_left != '0) &&
                    ((r_hold_cnt == '0) || ((r_hold_cnt == HW'(1)) && w_shift));
  assign w_accept = w_fetch && word_valid;
  assign w_flush  = (r_state == FLUSH);

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = LOAD;
      LOAD:    if (w_shift && (r_bit_cnt == CW'(1))) w_state_nxt = FLUSH;
      // Leave once the packer could emit its partial word (or had none).
      FLUSH:   if (!w_stall) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    word_ready = 1'b0;
    ccff_en    = 1'b0;
    ccff_head  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      LOAD: begin
        word_ready = w_fetch;
        ccff_en    = w_shift;
        ccff_head  = w_shift & r_hold[WORD_W-1];
        busy       = 1'b1;
      end
      FLUSH:   busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_bit_cnt    <= '0;
      r_hold       <= '0;
      r_hold_cnt   <= '0;
      r_words_left <= '0;
    end else if (r_state == IDLE) begin
      r_bit_cnt    <= CW'(CHAIN_LEN);
      r_hold_cnt   <= '0;
      r_words_left <= NW'(NUM_WORDS);
    end else begin
      if (w_shift) begin
        r_bit_cnt  <= r_bit_cnt - CW'(1);
        r_hold     <= r_hold << 1;
        r_hold_cnt <= r_hold_cnt - HW'(1);
      end
      // A fresh word overrides the drained holding register; the final word
      // only exposes its top LAST_BITS, the rest is never shifted.
      if (w_accept) begin
        r_hold       <= word_data;
        r_hold_cnt   <= (r_words_left == NW'(1)) ? HW'(LAST_BITS) : HW'(WORD_W);
        r_words_left <= r_words_left - NW'(1);
      end
    end
  end

  ccff_rb_packer #(
    .WORD_W(WORD_W)
  ) u_rb_packer (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .i_shift   (w_shift),
    .i_tail    (ccff_tail),
    .i_flush   (w_flush),
    .i_rb_ready(rb_ready),
    .o_rb_valid(rb_valid),
    .o_rb_data (rb_data),
    .o_stall   (w_stall)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: behavioural chain model, word-level expected streams.
// Latency: n/a.
// Backpressure: exercised via word_valid gaps and rb_ready holds.
module tb_ccff_chain_loader;

  localparam int CHAIN_LEN = 58;
  localparam int WORD_W    = 8;
  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  localparam int M_NOM    = 0;
  localparam int M_STARVE = 1;
  localparam int M_BP     = 2;
  localparam int M_RAND   = 3;
  localparam int M_RST    = 4;
  localparam int M_ISTART = 5;

  logic              prog_clk = 1'b0;
  logic              pReset;
  logic              start;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;
  logic              ccff_head;
  logic              ccff_en;
  logic              ccff_tail;
  logic              rb_valid;
  logic [WORD_W-1:0] rb_data;
  logic              rb_ready;
  logic              busy;
  logic              done;

  ccff_chain_loader #(
    .CHAIN_LEN(CHAIN_LEN),
    .WORD_W   (WORD_W)
  ) dut (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .start     (start),
    .word_valid(word_valid),
    .word_data (word_data),
    .word_ready(word_ready),
    .ccff_head (ccff_head),
    .ccff_en   (ccff_en),
    .ccff_tail (ccff_tail),
    .rb_valid  (rb_valid),
    .rb_data   (rb_data),
    .rb_ready  (rb_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 prog_clk = ~prog_clk;

  // Downstream chain: a plain shift register gated by ccff_en.
  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] chain_seed;
  logic                 chain_init;
  assign ccff_tail = chain[CHAIN_LEN-1];
  always @(posedge prog_clk) begin
    if (chain_init)   chain <= chain_seed;
    else if (ccff_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic string mname(input int m);
    case (m)
      M_NOM:    return "nom";
      M_STARVE: return "starve";
      M_BP:     return "bp";
      M_RAND:   return "rand";
      M_RST:    return "rst";
      default:  return "istart";
    endcase
  endfunction

  task automatic do_load(input int mode);
    logic [WORD_W-1:0]    words  [NWORDS];
    logic [WORD_W-1:0]    rb_got [NWORDS];
    logic [CHAIN_LEN-1:0] snap, exp_bits, got_bits;
    logic [WORD_W-1:0]    exp_w, prev_rbd;
    int widx, cyc, n_en, n_rb, n_done, first_acc, done_cyc, gap, stall_bad, hold_cnt, starve_left, s;
    bit acc, prev_stall, trig, stop;
    string nm;

    nm = mname(mode);
    widx = 0; cyc = 0; n_en = 0; n_rb = 0; n_done = 0; first_acc = -1; done_cyc = -1;
    gap = 0; stall_bad = 0; hold_cnt = 0; starve_left = 0;
    prev_stall = 0; prev_rbd = '0; trig = 0; stop = 0;
    got_bits = '0;

    for (int i = 0; i < NWORDS; i++) words[i] = WORD_W'($urandom);
    if (mode == M_NOM) begin
      words[0] = 8'hA5;
      words[1] = 8'h3C;
      words[NWORDS-1] = 8'hC0;
    end
    // Bitstream order: word 0 first, MSB first within each word.
    for (int b = 0; b < CHAIN_LEN; b++)
      exp_bits[CHAIN_LEN-1-b] = words[b / WORD_W][WORD_W-1-(b % WORD_W)];
    snap = chain;

    @(posedge prog_clk); #1;
    start      = 1'b1;
    word_valid = 1'b1;
    word_data  = words[0];
    rb_ready   = (mode == M_BP) ? 1'b0 : 1'b1;

    while (!stop) begin
      @(negedge prog_clk);
      acc = word_valid && word_ready;
      if (acc && first_acc < 0) first_acc = cyc;
      if (mode == M_NOM && cyc == 0) chk("nom_idle_busy", busy, 0);
      if (mode == M_NOM && cyc == 1) chk("nom_start_lat", {busy, word_ready}, 2'b11);
      if (!ccff_en && n_en > 0 && n_en < CHAIN_LEN) gap++;
      if (ccff_en) begin
        if (n_en < CHAIN_LEN) got_bits[CHAIN_LEN-1-n_en] = ccff_head;
        n_en++;
      end
      if (rb_valid && !rb_ready) begin
        if (ccff_en) stall_bad++;
        if (prev_stall && rb_data !== prev_rbd) stall_bad++;
        hold_cnt++;
      end
      prev_stall = rb_valid && !rb_ready;
      prev_rbd   = rb_data;
      if (rb_valid && rb_ready) begin
        if (n_rb < NWORDS) rb_got[n_rb] = rb_data;
        n_rb++;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end

      @(posedge prog_clk); #1;
      cyc++;
      start = 1'b0;
      if (acc) widx++;
      if (mode == M_STARVE && n_en == 23 && !trig) begin trig = 1; starve_left = 5; end
      if (mode == M_ISTART && n_en == 20 && !trig) begin trig = 1; start = 1'b1; end
      if (mode == M_BP && hold_cnt >= 10) rb_ready = 1'b1;
      if (mode == M_RAND) rb_ready = ($urandom_range(0, 9) < 7);
      if (done_cyc >= 0) rb_ready = 1'b1;
      word_valid = (widx < NWORDS) && (starve_left == 0);
      if (mode == M_RAND && $urandom_range(0, 3) == 0) word_valid = 1'b0;
      if (starve_left > 0) starve_left--;
      word_data = (widx < NWORDS) ? words[widx] : '0;

      if (mode == M_RST && n_en == 30) begin
        pReset = 1'b0;
        #1;
        chk("rst_mid_ctl", {ccff_head, ccff_en, word_ready, rb_valid, busy, done}, 6'b0);
        chk("rst_mid_rbd", rb_data, 0);
        word_valid = 1'b0;
        repeat (3) begin
          @(negedge prog_clk);
          if (done) n_done++;
        end
        @(posedge prog_clk); #1;
        pReset = 1'b1;
        stop = 1;
      end
      if (done_cyc >= 0 && cyc > done_cyc + 4) stop = 1;
      if (!stop && cyc > 600) begin
        chk({nm, "_timeout"}, 0, 1);
        stop = 1;
      end
    end
    word_valid = 1'b0;
    rb_ready   = 1'b1;

    if (mode == M_RST) begin
      chk("rst_no_done", n_done, 0);
    end else begin
      chk({nm, "_en_cnt"}, n_en, CHAIN_LEN);
      chk({nm, "_head_bits"}, got_bits, exp_bits);
      chk({nm, "_done_cnt"}, n_done, 1);
      chk({nm, "_stall"}, stall_bad, 0);
      chk({nm, "_rb_cnt"}, n_rb, NWORDS);
      // Readback is the previous chain contents, oldest bit first, last word zero-padded.
      for (int k = 0; k < NWORDS; k++) begin
        exp_w = '0;
        for (int j = 0; j < WORD_W; j++) begin
          s = k * WORD_W + j;
          if (s < CHAIN_LEN) exp_w[WORD_W-1-j] = snap[CHAIN_LEN-1-s];
        end
        chk($sformatf("%s_rb_word%0d", nm, k), rb_got[k], exp_w);
      end
      if (mode == M_NOM) begin
        chk("nom_done_lat", done_cyc - first_acc, CHAIN_LEN + 2);
        chk("nom_gap", gap, 0);
      end
      if (mode == M_STARVE) begin
        chk("starve_done_lat", done_cyc - first_acc, CHAIN_LEN + 2 + 5);
        chk("starve_gap", gap, 5);
      end
      if (mode == M_BP) begin
        chk("bp_done_lat", done_cyc - first_acc, CHAIN_LEN + 2 + 10);
        chk("bp_gap", gap, 10);
      end
    end
  endtask

  initial begin
    pReset     = 1'b1;
    start      = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;
    rb_ready   = 1'b1;
    chain_init = 1'b1;
    chain_seed = CHAIN_LEN'({$urandom, $urandom});
    #1 pReset = 1'b0;
    #1;
    chk("rst_ctl", {ccff_head, ccff_en, word_ready, rb_valid, busy, done}, 6'b0);
    chk("rst_rbd", rb_data, 0);
    repeat (3) @(posedge prog_clk);
    #1;
    chain_init = 1'b0;
    pReset     = 1'b1;
    @(negedge prog_clk);
    chk("idle_after_rst", {busy, word_ready, ccff_en}, 3'b0);

    do_load(M_NOM);
    do_load(M_NOM);
    do_load(M_STARVE);
    do_load(M_BP);
    do_load(M_RST);
    do_load(M_RAND);
    do_load(M_ISTART);
    for (int r = 0; r < 3; r++) do_load(M_RAND);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
